int_ctrl: RTL
=============

# int_ctrl

Mode-2 interrupt controller that arbitrates up to seven interrupt requesters (ACIA, timers, future peripherals) onto the single Z80 `int_n` line. It prioritises pending sources, sequences the INT/acknowledge handshake, supplies the IM2 vector byte during the acknowledge cycle, and tracks in-service state for fully nested servicing. It sits between the peripherals and the `tv80n` core. Its I/O registers are decoded by the top level. Its data output is muxed into `cpu_din`.

## Interface
- `N_SRC`, 7: number of sources, 1..7; index 0 is highest priority.
- `VECTOR_BASE`, 8'h00: IM2 vector low byte; bits [3:0] must be 0.
- `clk`  in  1  system clock (25 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `cen`  in  1  CPU clock enable; acknowledge sampling is qualified by it.
- `irq_n`  in  N_SRC  active-low requests, synchronous to `clk`.
- `cs`  in  1  register select from top-level I/O decode (`!iorq_n` already qualified).
- `rs`  in  2  register offset.
- `wr_n`, `rd_n`  in  1  CPU strobes.
- `m1_n`, `iorq_n`  in  1  CPU strobes; both low = interrupt acknowledge.
- `data_in`  in  8  CPU write data.
- `data_out`  out  8  register read data or vector; 8'hff otherwise.
- `vec_oe`  out  1  high while the vector is driven; top muxes it first into `cpu_din`.
- `int_n`  out  1  registered active-low interrupt to the CPU.

## Operation
- Registers:
  - rs=0 MASK: rw, 1 = enabled.
  - rs=1 PEND: read pending; write-1-to-clear for edge sources.
  - rs=2 MODE: rw, 1 = falling-edge, 0 = level.
  - rs=3: read ISR; write any value = EOI.
- Reset values: all registers 0, `int_n`=1, `vec_oe`=0, `data_out`=8'hff, state IDLE.
- Register writes take effect on the `clk` edge where `cs && !wr_n && cen`.
- Pending logic:
  - Level source: pending = !irq_n.
  - Edge source: pending bit set on a 1→0 transition of the registered `irq_n`.
  - Edge pending is cleared by W1C or by acknowledge.
  - If set and clear occur on the same edge, set wins.
- Eligible = pending & MASK.
- `win` = lowest eligible index that is strictly higher in priority than the highest ISR bit. `win`=7 means none.
- State machine:
  - IDLE → REQ when `win`≠7.
  - REQ holds `int_n`=0. REQ → IDLE if `win` becomes 7 before acknowledge (MASK write, level released).
  - REQ or IDLE → ACK when `!m1_n && !iorq_n` is sampled on a `cen` edge. The index is frozen into `cur` on that edge.
  - ACK → IDLE when the acknowledge condition drops. On that edge, if `cur`≠7: set ISR[`cur`] and clear edge-pending[`cur`].
- Vector = `VECTOR_BASE | {cur,1'b0}`.
  - `cur`=7 gives the spurious vector `VECTOR_BASE+0x0E`. No ISR bit is set.
- EOI clears the highest-priority set ISR bit. EOI with ISR=0 is a no-op.
- Reset mid-ACK returns to IDLE immediately, with registers and outputs at reset values.

## Timing
- `int_n` is registered: it falls one `clk` after `win` becomes valid, and rises one `clk` after `win`=7 or on entering ACK.
- `vec_oe`/`data_out` are combinational from `!m1_n && !iorq_n`.
  - On the acknowledge cycle, the value is computed from the live `win`.
  - Afterwards it comes from frozen `cur`, so it is stable for the full acknowledge.
- Register read data is combinational from `cs && !rd_n`. There is no read side effect.
- An ISR update is visible to `win` on the `clk` after ACK exits. A new request can therefore reassert `int_n` no earlier than 2 `clk` after acknowledge ends.

## Structure
- Shared package `int_ctrl_pkg`:
  - register offsets `REG_MASK`/`REG_PEND`/`REG_MODE`/`REG_ISR`;
  - state encoding IDLE/REQ/ACK;
  - `SPURIOUS_IDX`=3'd7.
- Sub-module `prio_enc`: N-bit lowest-index-first encoder. It returns 3'd7 when no bit is set. It is instantiated twice: once for eligible, once for ISR.

## Test plan
- MASK=0x01, level source 0 asserted → `int_n` low within 2 clk. On acknowledge, `data_out`=`VECTOR_BASE`+0x00 and `vec_oe`=1; ISR=0x01 after ACK.
- Sources 2 and 5 both edge-pending, MASK=0x24 → first vector `VECTOR_BASE`+0x04. Then EOI → next vector +0x0A; ISR=0x20.
- Nesting: ISR=0x08 (source 3 in service), source 5 pending → `int_n` stays 1. Source 1 pending → `int_n`=0.
- Level source released between INT and acknowledge (no `win` change in time) → vector `VECTOR_BASE`+0x0E; ISR unchanged.
- PEND W1C of bit 4 on the same `clk` as a new falling edge on source 4 → PEND[4] reads 1.
- `rst_n` pulsed low during ACK → `int_n`=1, `vec_oe`=0, `data_out`=8'hff; MASK/PEND/MODE/ISR=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
//   Shared definitions for the IM2 interrupt controller: register offsets,
//   FSM state encoding, the "no source" index and the vector helper.
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_ISR  = 2'd3;

    // Index returned when no source qualifies; also selects the spurious vector.
    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Vector byte: base has bits [3:0] clear, so OR acts as addition.
    function automatic logic [7:0] vector_byte(input logic [7:0] base,
                                               input logic [2:0] idx);
        return base | {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if
//   CPU-side bus of the interrupt controller.
//   master : CPU / top-level decode (drives strobes, select, write data)
//   slave  : int_ctrl (drives read data / vector, vec_oe, int_n)
//   Signals: cs, rs[1:0], wr_n, rd_n, m1_n, iorq_n, data_in[7:0],
//            data_out[7:0], vec_oe, int_n.
//   Handshake: an acknowledge is m1_n and iorq_n both low; the controller
//   presents the vector combinationally (vec_oe=1) for as long as that
//   condition holds and considers the acknowledge finished when it drops.
// -----------------------------------------------------------------------------
interface int_ctrl_if;
    logic       cs;
    logic [1:0] rs;
    logic       wr_n;
    logic       rd_n;
    logic       m1_n;
    logic       iorq_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       vec_oe;
    logic       int_n;

    modport master (
        output cs, rs, wr_n, rd_n, m1_n, iorq_n, data_in,
        input  data_out, vec_oe, int_n
    );

    modport slave (
        input  cs, rs, wr_n, rd_n, m1_n, iorq_n, data_in,
        output data_out, vec_oe, int_n
    );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
//   Lowest-index-first priority encoder.
//   req [N-1:0] : request vector, bit 0 is highest priority
//   idx [2:0]   : index of lowest set bit, 3'd7 when none set
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int N = 7
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx
);
    always_comb begin
        idx = 3'd7;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end
endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//   Z80 mode-2 interrupt controller for up to seven sources. Prioritises
//   pending sources, drives int_n, supplies the IM2 vector during the
//   acknowledge cycle and tracks in-service sources for nested servicing.
//   Ports:
//     clk, rst_n   system clock, async active-low reset
//     cen          CPU clock enable (qualifies writes and acknowledge sampling)
//     irq_n        active-low requests, synchronous to clk
//     bus          int_ctrl_if.slave (CPU strobes, register access, vector)
//     state_dbg    current FSM state
//   Registers (rs): 0 MASK rw, 1 PEND r / W1C, 2 MODE rw (1=edge),
//                   3 ISR r / write = EOI.
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC       = 7,
    parameter logic [7:0] VECTOR_BASE = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [N_SRC-1:0] irq_n,
    int_ctrl_if.slave        bus,
    output state_t           state_dbg
);

    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] edge_pend_q;
    logic [N_SRC-1:0] edge_pend_d;
    logic [N_SRC-1:0] isr_q;
    logic [N_SRC-1:0] isr_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] irq_q2;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] fall;
    logic [N_SRC-1:0] wdata;

    state_t     state_q;
    logic [2:0] cur_q;
    logic       int_n_q;

    logic [2:0] elig_idx;
    logic [2:0] isr_idx;
    logic [2:0] win;
    logic [2:0] vec_idx;
    logic       ack;
    logic       wr_en;
    logic       ack_exit;
    logic       eoi;
    logic       w1c;
    logic [7:0] data_out_c;
    logic       unused_data;

    assign ack      = !bus.m1_n && !bus.iorq_n;
    assign wr_en    = bus.cs && !bus.wr_n && cen;
    assign eoi      = wr_en && (bus.rs == REG_ISR);
    assign w1c      = wr_en && (bus.rs == REG_PEND);
    assign ack_exit = (state_q == ACK) && !ack;
    assign wdata    = bus.data_in[N_SRC-1:0];
    assign unused_data = ^bus.data_in[7:N_SRC];

    // Falling edge of the registered request.
    assign fall     = irq_q2 & ~irq_q;
    assign pend     = (mode_q & edge_pend_q) | (~mode_q & ~irq_n);
    assign eligible = pend & mask_q;

    prio_enc #(.N(N_SRC)) u_elig_enc (.req(eligible), .idx(elig_idx));
    prio_enc #(.N(N_SRC)) u_isr_enc  (.req(isr_q),    .idx(isr_idx));

    // Only a source strictly above the highest in-service one may interrupt.
    assign win = (elig_idx < isr_idx) ? elig_idx : SPURIOUS_IDX;

    // Next-state for edge-pending and in-service bits.
    always_comb begin
        edge_pend_d = edge_pend_q;
        isr_d       = isr_q;
        for (int i = 0; i < N_SRC; i++) begin
            // Clears first, sets after: a set on the same edge wins.
            if (w1c && wdata[i])                 edge_pend_d[i] = 1'b0;
            if (ack_exit && (cur_q == 3'(i)))    edge_pend_d[i] = 1'b0;
            if (fall[i] && mode_q[i])            edge_pend_d[i] = 1'b1;

            if (eoi && (isr_idx == 3'(i)))       isr_d[i] = 1'b0;
            if (ack_exit && (cur_q == 3'(i)))    isr_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            isr_q       <= '0;
            irq_q       <= '1;
            irq_q2      <= '1;
        end else begin
            irq_q       <= irq_n;
            irq_q2      <= irq_q;
            edge_pend_q <= edge_pend_d;
            isr_q       <= isr_d;
            if (wr_en && (bus.rs == REG_MASK)) mask_q <= wdata;
            if (wr_en && (bus.rs == REG_MODE)) mode_q <= wdata;
        end
    end

    // Request / acknowledge sequencer with registered int_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= SPURIOUS_IDX;
            int_n_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, REQ: begin
                    if (cen && ack) begin
                        state_q <= ACK;
                        cur_q   <= win;
                        int_n_q <= 1'b1;
                    end else if (win != SPURIOUS_IDX) begin
                        state_q <= REQ;
                        int_n_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        int_n_q <= 1'b1;
                    end
                end
                ACK: begin
                    int_n_q <= 1'b1;
                    if (!ack) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    int_n_q <= 1'b1;
                end
            endcase
        end
    end

    // On the first acknowledge cycle cur is not yet frozen, so use live win.
    assign vec_idx = (state_q == ACK) ? cur_q : win;

    always_comb begin
        data_out_c = 8'hff;
        if (ack) begin
            data_out_c = vector_byte(VECTOR_BASE, vec_idx);
        end else if (bus.cs && !bus.rd_n) begin
            case (bus.rs)
                REG_MASK: data_out_c = {{(8-N_SRC){1'b0}}, mask_q};
                REG_PEND: data_out_c = {{(8-N_SRC){1'b0}}, pend};
                REG_MODE: data_out_c = {{(8-N_SRC){1'b0}}, mode_q};
                default:  data_out_c = {{(8-N_SRC){1'b0}}, isr_q};
            endcase
        end
    end

    assign bus.data_out = data_out_c;
    assign bus.vec_oe   = ack;
    assign bus.int_n    = int_n_q;
    assign state_dbg    = state_q;

endmodule
